s2pc_receiver: RTL and testbench

S2PC_RECEIVER -- requirements
Module: s2pc_receiver

---
 rtl/s2pc_receiver.sv | 225 ++++++++++++++++++++++
 tb/tb_s2pc_receiver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/s2pc_receiver.sv
// ---------------------------------------------------------------------------
// s2pc_receiver -- serial-to-parallel frame receiver
//
// Receives WIDTH data bits LSB first on sin, one per clock, starting with the
// cycle in which start is high. The completed word is presented on p_out
// together with a one-cycle valid pulse. A start seen while a frame is in
// progress is ignored.
//
// Optional feature (macro S2PC_PARITY_EN): one even-parity bit follows the
// last data bit. p_out/valid move one cycle later and parity_err reports the
// XOR of all data bits and the parity bit. With the macro undefined the
// parity state is absent and parity_err is tied to 0.
//
// Parameters:
//   WIDTH       data bits per frame, 2..32
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start       frame-start strobe, coincident with data bit 0 on sin
//   sin         serial data, LSB first
//   p_out       last completed frame (registered)
//   valid       one-cycle pulse, p_out updated this cycle
//   busy        high while a frame is being received after its start cycle
//   parity_err  parity result for the frame flagged by valid
// ---------------------------------------------------------------------------

// Controller: sequences IDLE -> SHIFT (-> PARITY) -> IDLE.
module s2pc_ctrl (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic last_bit,   // datapath is sampling data bit WIDTH-1
   output logic first_bit,  // load bit 0 and restart the counter
   output logic shift_en,   // sample sin at the counter position
   output logic done,       // frame complete: update p_out and pulse valid
   output logic busy
);

`ifdef S2PC_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t state_q, state_d;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      first_bit = 1'b0;
      shift_en  = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               first_bit = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // start is ignored here; sin is always data
            shift_en = 1'b1;
            if (last_bit) begin
`ifdef S2PC_PARITY_EN
               state_d = PARITY;
`else
               done    = 1'b1;
               state_d = IDLE;
`endif
            end
         end
`ifdef S2PC_PARITY_EN
         PARITY: begin
            done    = 1'b1;
            state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

endmodule

// Datapath: shift register, bit counter, output register and flags.
module s2pc_dpath #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             first_bit,
   input  logic             shift_en,
   input  logic             done,
   output logic             last_bit,
   output logic [WIDTH-1:0] p_out,
   output logic             valid,
   output logic             parity_err
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] p_out_q, p_out_d;
   logic             valid_q, valid_d;

   assign last_bit = (count_q == CW'(WIDTH - 1));

   // NOTE: the shift register is reset along with everything else because
   // reset must leave all state at zero; it is small, so this costs nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         shift_q <= '0;
         p_out_q <= '0;
         valid_q <= 1'b0;
      end else begin
         count_q <= count_d;
         shift_q <= shift_d;
         p_out_q <= p_out_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      count_d = count_q;
      shift_d = shift_q;
      p_out_d = p_out_q;
      valid_d = 1'b0;
      if (first_bit) begin
         // clear stale bits so a new frame never carries old data
         shift_d    = '0;
         shift_d[0] = sin;
         count_d    = CW'(1);
      end else if (shift_en) begin
         shift_d[count_q] = sin;
         count_d          = last_bit ? '0 : count_q + CW'(1);
      end
      // p_out is only ever written here, so mid-frame shifting never shows
      if (done) begin
         valid_d = 1'b1;
`ifdef S2PC_PARITY_EN
         p_out_d = shift_q;            // sin carries the parity bit
`else
         p_out_d = shift_d;            // includes the last data bit from sin
`endif
      end
   end

`ifdef S2PC_PARITY_EN
   logic parity_err_q, parity_err_d;

   always_ff @(posedge clk) begin
      if (rst) parity_err_q <= 1'b0;
      else     parity_err_q <= parity_err_d;
   end

   // even parity: XOR over data and parity bit is 0 for a good frame;
   // held between valid pulses, p_out updates regardless
   always_comb begin
      parity_err_d = parity_err_q;
      if (done) parity_err_d = (^shift_q) ^ sin;
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign p_out = p_out_q;
   assign valid = valid_q;

endmodule

// Top: controller plus datapath.
module s2pc_receiver #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sin,
   output logic [WIDTH-1:0] p_out,
   output logic             valid,
   output logic             busy,
   output logic             parity_err
);

   logic last_bit, first_bit, shift_en, done;

   s2pc_ctrl u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .last_bit  (last_bit),
      .first_bit (first_bit),
      .shift_en  (shift_en),
      .done      (done),
      .busy      (busy)
   );

   s2pc_dpath #(.WIDTH(WIDTH)) u_dpath (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .first_bit  (first_bit),
      .shift_en   (shift_en),
      .done       (done),
      .last_bit   (last_bit),
      .p_out      (p_out),
      .valid      (valid),
      .parity_err (parity_err)
   );

endmodule

// File: tb/tb_s2pc_receiver.sv
// ---------------------------------------------------------------------------
// tb_s2pc_receiver -- table-driven bench for s2pc_receiver (WIDTH = 8)
//
// Each table row holds the inputs driven for one cycle and the outputs
// expected in the following cycle. Frames are added as row groups whose
// expected values are written out by hand (frame word, parity result).
// Works with or without S2PC_PARITY_EN defined.
// ---------------------------------------------------------------------------
module tb_s2pc_receiver;

   localparam int WIDTH = 8;
`ifdef S2PC_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             sin = 1'b0;
   logic [WIDTH-1:0] p_out;
   logic             valid;
   logic             busy;
   logic             parity_err;

   s2pc_receiver #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .sin        (sin),
      .p_out      (p_out),
      .valid      (valid),
      .busy       (busy),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             rst;
      logic             start;
      logic             sin;
      logic             valid;
      logic             busy;
      logic [WIDTH-1:0] pout;
      logic             perr;
   } vec_t;

   vec_t             vecs[$];
   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] exp_pout = '0;   // expected held p_out while building
   logic             exp_perr = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic s, input logic d,
                      input logic v, input logic b,
                      input logic [WIDTH-1:0] p, input logic pe);
      vec_t row;
      row.rst = r; row.start = s; row.sin = d;
      row.valid = v; row.busy = b; row.pout = p; row.perr = pe;
      vecs.push_back(row);
   endtask

   // A full frame: start_mask marks cycles with start high (bit 0 = real
   // start, others are spurious mid-frame starts). perr_if_par is the
   // hand-computed parity result; it is 0 whenever parity is disabled.
   task automatic add_frame(input logic [WIDTH-1:0] data,
                            input logic [WIDTH-1:0] start_mask,
                            input logic par_bit, input logic perr_if_par);
      int n = WIDTH + PAR;
      for (int i = 0; i < n; i++) begin
         logic d = (i < WIDTH) ? data[i] : par_bit;
         logic s = (i < WIDTH) ? start_mask[i] : 1'b0;
         logic last = (i == n - 1);
         if (last) begin
            exp_pout = data;
            exp_perr = (PAR != 0) ? perr_if_par : 1'b0;
         end
         add(1'b0, s, d, last, !last, exp_pout, exp_perr);
      end
   endtask

   task automatic add_idle();
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_pout, exp_perr);
   endtask

   task automatic add_reset(input logic s);
      exp_pout = '0;
      exp_perr = 1'b0;
      add(1'b1, s, 1'b1, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      // ---- build table ----
      add_reset(1'b0);
      add_reset(1'b1);                          // rst dominates start
      add_idle();                               // stays IDLE after it
      add_frame(8'hA5, 8'h01, 1'b0, 1'b0);      // even parity bit 0 -> ok
      add_idle();                               // valid drops, p_out held
      add_frame(8'h3C, 8'h01, 1'b0, 1'b0);      // back-to-back pair
      add_frame(8'hC3, 8'h01, 1'b0, 1'b0);
      add_idle();
      add_frame(8'h0F, 8'h09, 1'b0, 1'b0);      // spurious start at bit 3
      add_idle();
      // frame 8'h81 aborted by reset in cycle k+4
      for (int i = 0; i < 4; i++)
         add(1'b0, (i == 0), (i == 0), 1'b0, 1'b1, exp_pout, exp_perr);
      add_reset(1'b0);
      add_idle();
      add_frame(8'h81, 8'h01, 1'b0, 1'b0);
      add_idle();
      add_frame(8'hA5, 8'h01, 1'b1, 1'b1);      // bad parity, p_out still A5
      add_idle();
      add_idle();                               // parity_err held

      // ---- apply ----
      for (int r = 0; r < vecs.size(); r++) begin
         @(negedge clk);
         rst   = vecs[r].rst;
         start = vecs[r].start;
         sin   = vecs[r].sin;
         @(posedge clk);
         #1;
         check($sformatf("row%0d valid", r), 32'(valid), 32'(vecs[r].valid));
         check($sformatf("row%0d busy", r), 32'(busy), 32'(vecs[r].busy));
         check($sformatf("row%0d p_out", r), 32'(p_out), 32'(vecs[r].pout));
         check($sformatf("row%0d parity_err", r), 32'(parity_err),
               32'(vecs[r].perr));
      end

      // ---- hand sequence: count valid pulses over a frame with a mid-frame
      // start; exactly one pulse, at cycle k+WIDTH+PAR ----
      begin
         int pulses = 0;
         int pulse_at = -1;
         for (int c = 0; c < WIDTH + PAR + 4; c++) begin
            @(negedge clk);
            rst   = 1'b0;
            start = (c == 0) || (c == 2);
            sin   = (c < WIDTH) ? ((8'h5A >> c) & 1) : 1'b0;
            @(posedge clk);
            #1;
            if (valid) begin
               pulses++;
               pulse_at = c + 1;
            end
         end
         check("seq pulse count", 32'(pulses), 32'd1);
         check("seq pulse cycle", 32'(pulse_at), 32'(WIDTH + PAR));
         check("seq p_out", 32'(p_out), 32'h5A);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
